// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, halt word, state codes and FIFO entry layout for ifetch_ctrl.
package ifetch_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;
  typedef logic [1:0] state_t;
  localparam state_t ST_BOOT = 2'd0;
  localparam state_t ST_RUN = 2'd1;
  localparam state_t ST_HALTED = 2'd2;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: prefetch FIFO of {instr, pc}; flush beats push/pop, head reads zero when empty.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  fetch_t din,
  output logic   full,
  output logic   empty,
  output fetch_t head
);
  localparam int AW = $clog2(DEPTH);
  fetch_t mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign head = empty ? '0 : mem[rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch PC, prefetch buffering and redirect handling for the 16-bit lab core.
// Define IFETCH_HALT_EN to stop fetching at a HALT_WORD fetch.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [7:0]  IMEM_ADDR,
  input  logic [15:0] IMEM_Q,
  output logic        INSTR_VALID,
  output logic [15:0] INSTR,
  output logic [7:0]  INSTR_PC,
  input  logic        INSTR_READY,
  input  logic        REDIRECT,
  input  logic [7:0]  REDIRECT_PC,
  output logic        HALTED
);
  state_t state;
  logic [7:0] fetch_pc;
  logic full, empty, pop, flush, eligible, is_halt, push;
  fetch_t head;
  assign pop = INSTR_VALID && INSTR_READY;
  assign flush = REDIRECT && state != ST_BOOT;
  // A full FIFO can still take a word when decode frees a slot in the same cycle.
  assign eligible = state == ST_RUN && !flush && (!full || pop);
`ifdef IFETCH_HALT_EN
  assign is_halt = IMEM_Q == HALT_WORD;
  assign HALTED = state == ST_HALTED;
`else
  assign is_halt = 1'b0;
  assign HALTED = 1'b0;
`endif
  assign push = eligible && !is_halt;
  assign IMEM_ADDR = fetch_pc;
  assign INSTR_VALID = !empty;
  assign INSTR = head.instr;
  assign INSTR_PC = head.pc;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_BOOT;
      fetch_pc <= {RESET_PC[7:1], 1'b0};
    end else if (state == ST_BOOT) begin
      state <= ST_RUN;
    end else if (flush) begin
      state <= ST_RUN;
      fetch_pc <= {REDIRECT_PC[7:1], 1'b0};
    end else begin
      if (push) fetch_pc <= fetch_pc + 8'd2;
      if (eligible && is_halt) state <= ST_HALTED;
    end
  end
  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (CLK),
    .rst  (RESET),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  ({IMEM_Q, fetch_pc}),
    .full (full),
    .empty(empty),
    .head (head)
  );
endmodule
